mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single unified instruction/data RAM of the multicycle MIPS between the CPU datapath (port 0) and a program/data loader (port 1). The loader replaces direct memory initialisation: it writes program words and operands, such as the Fibonacci input at word 527, while the CPU is running or stalled. The arbiter serialises word accesses with a req/ack handshake, fair round-robin selection and a fixed three-cycle access sequence.

## Interface
- DW, 32, data word width
- AW, 10, word-address width (RAM depth 2^AW words)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req=1
- cpu_addr  in  AW  CPU word address; stable while cpu_req=1
- cpu_wdata  in  DW  CPU write data; stable while cpu_req=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data; valid in the cpu_ack cycle, held until next CPU ack
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request, same rules as CPU port
- ld_ack  out  1  loader completion pulse
- ld_rdata  out  DW  loader read data; same rules as cpu_rdata
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM combinational read data for mem_addr
- busy  out  1  1 when the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE. A registered `sel` records the granted port (0 = CPU, 1 = loader). A registered `last` records the previously granted port.
- IDLE transitions:
  - If no request: stay in IDLE.
  - If exactly one req is high: grant that port, go to ACCESS.
  - If both reqs are high: grant the port ≠ `last`, go to ACCESS.
- ACCESS lasts exactly one cycle:
  - mem_addr and mem_wdata come from the selected port.
  - mem_we = selected port's we. This is the only state in which mem_we can be 1.
  - If the access is a read, mem_rdata is captured into the selected port's rdata register at the end of the cycle.
  - `last` ← `sel`. Go to DONE.
- DONE lasts exactly one cycle:
  - The selected port's ack = 1; the other ack = 0.
  - All reqs are ignored in this cycle. Go to IDLE.
- The requester may keep req high after ack to issue a back-to-back access. It must update addr/we/wdata in the cycle after ack.
- Outside ACCESS, mem_we = 0. mem_addr and mem_wdata are driven from port `sel` but carry no meaning.
- The rdata register of the non-selected port is never modified.
- Fairness: with both ports requesting continuously, grants strictly alternate. Neither port waits more than one foreign transfer (3 cycles) before its own grant.
- A req that drops before its ack is a protocol violation. Behaviour in that case is unspecified, but the FSM must still return to IDLE within 2 cycles.

## Timing
- Reset (rst=0 at an edge): state=IDLE, sel=0, last=1 (the CPU wins the first tie), cpu_ack=0, ld_ack=0, cpu_rdata=0, ld_rdata=0, busy=0, mem_we=0. The reset value of mem_addr follows from sel=0 (CPU port).
- Reset mid-operation: an ACCESS or DONE state is abandoned immediately. No ack is issued.
  - A write that was in ACCESS in the same cycle as reset still has mem_we asserted in that cycle, because mem_we is combinational from state. From the next cycle on, mem_we=0.
- Latency: req sampled high in IDLE at edge k → ACCESS during cycle k+1 → ack during cycle k+2 → IDLE at cycle k+3.
- Throughput: one transfer per 3 cycles per arbiter, whichever ports are involved.
- All outputs except mem_we, mem_addr and mem_wdata are registered. Those three are combinational decodes of state and sel.

## Test plan
- Reset: hold rst=0 for 3 cycles with both reqs high → acks=0, mem_we=0, busy=0, rdata=0. Release → the CPU is granted first.
- Loader write, then CPU read:
  - ld writes addr 527, data 5 → mem_we=1 for exactly one cycle with mem_addr=527, mem_wdata=5, and ld_ack 1 cycle later.
  - cpu then reads 527 → cpu_rdata=5 at cpu_ack, 2 cycles after the grant edge.
- Simultaneous requests:
  - Both reqs held high for 12 cycles → 4 grants in the order cpu, ld, cpu, ld. Each ack is a single-cycle pulse, spaced 3 cycles apart.
- Data isolation:
  - cpu reads addr 1 (RAM holds 0x20190200), then ld reads addr 0 (RAM holds 0) → cpu_rdata stays 0x20190200 through the ld transfer. ld_rdata=0.
- Reset mid-access:
  - Drop rst during the ACCESS cycle of a ld read → no ld_ack, ld_rdata stays 0, state=IDLE next cycle.
- Back-to-back on one port:
  - cpu holds req high across 2 reads (addr 3, then addr 4) → acks occur 3 cycles apart with rdata 0x20110001, then 0x8F37000F.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, loader), the shared RAM and
// the arbiter. The arbiter connects through the slave modport.
interface mem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one RAM between the CPU (port 0)
// and the program/data loader (port 1). Each transfer is IDLE -> ACCESS -> DONE.
module mem_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ld_ack_q, ld_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ld_rdata_q, ld_rdata_d;
  logic          busy_q, busy_d;

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: grant, read capture, ack generation.
  // Acks and busy are computed from the next state so that the registered
  // copies line up with the DONE cycle and the non-IDLE states respectively.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req && bus.ld_req) begin
          sel_d   = ~last_q;
          state_d = S_ACCESS;
        end else if (bus.cpu_req) begin
          sel_d   = 1'b0;
          state_d = S_ACCESS;
        end else if (bus.ld_req) begin
          sel_d   = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        last_d  = sel_q;
        state_d = S_DONE;
        if (sel_q) begin
          ld_ack_d = 1'b1;
          if (!bus.ld_we) ld_rdata_d = bus.mem_rdata;
        end else begin
          cpu_ack_d = 1'b1;
          if (!bus.cpu_we) cpu_rdata_d = bus.mem_rdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // RAM port decode: address/data follow sel; write strobe only in ACCESS.
  always_comb begin
    bus.mem_addr  = sel_q ? bus.ld_addr  : bus.cpu_addr;
    bus.mem_wdata = sel_q ? bus.ld_wdata : bus.cpu_wdata;
    bus.mem_we    = (state_q == S_ACCESS) && (sel_q ? bus.ld_we : bus.cpu_we);
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM stub, transaction-level reference model and
// directed plus randomized transfers.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.DW(32), .AW(10)) bus();

  mem_arbiter #(.DW(32), .AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Power-on RAM contents (program image fragment plus filler pattern).
  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'd0:   init_word = 32'h0000_0000;
      10'd1:   init_word = 32'h2019_0200;
      10'd3:   init_word = 32'h2011_0001;
      10'd4:   init_word = 32'h8F37_000F;
      default: init_word = {22'h0, a} ^ 32'hA500_0000;
    endcase
  endfunction

  // RAM stub: combinational read, write on clock edge.
  logic [31:0] ram   [1024];
  bit          ram_v [1024];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr]   <= bus.mem_wdata;
      ram_v[bus.mem_addr] <= 1'b1;
    end
  end
  assign bus.mem_rdata = ram_v[bus.mem_addr] ? ram[bus.mem_addr] : init_word(bus.mem_addr);

  // Reference model state.
  logic [31:0] exp_mem [1024];
  logic [31:0] m_rd [2];
  bit          m_last;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdata_of(input bit p);
    return p ? bus.ld_rdata : bus.cpu_rdata;
  endfunction

  function automatic logic ack_of(input bit p);
    return p ? bus.ld_ack : bus.cpu_ack;
  endfunction

  task automatic do_reset();
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask

  // Serve one transfer starting from IDLE with at least one request pending.
  // The winner follows round-robin: when both request, the port not served last.
  task automatic serve(input bit drop);
    bit          w;
    bit          we;
    logic [9:0]  a;
    logic [31:0] wd;
    if (bus.cpu_req && bus.ld_req) w = ~m_last;
    else                           w = bus.ld_req;
    we = w ? bus.ld_we    : bus.cpu_we;
    a  = w ? bus.ld_addr  : bus.cpu_addr;
    wd = w ? bus.ld_wdata : bus.cpu_wdata;

    // ACCESS cycle
    tick();
    chk("acc_busy", bus.busy, 1);
    chk("acc_we", bus.mem_we, we);
    chk("acc_addr", bus.mem_addr, a);
    if (we) chk("acc_wdata", bus.mem_wdata, wd);
    chk("acc_acks", {bus.cpu_ack, bus.ld_ack}, 0);

    if (we) exp_mem[a] = wd;
    else    m_rd[w] = exp_mem[a];
    m_last = w;

    // DONE cycle
    tick();
    chk(w ? "ld_ack" : "cpu_ack", ack_of(w), 1);
    chk(w ? "cpu_ack_quiet" : "ld_ack_quiet", ack_of(~w), 0);
    chk("done_we", bus.mem_we, 0);
    chk(w ? "ld_rdata" : "cpu_rdata", rdata_of(w), m_rd[w]);
    chk(w ? "cpu_rdata_keep" : "ld_rdata_keep", rdata_of(~w), m_rd[~w]);
    if (drop) begin
      if (w) bus.ld_req = 1'b0;
      else   bus.cpu_req = 1'b0;
    end

    // back in IDLE
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_acks", {bus.cpu_ack, bus.ld_ack}, 0);
    chk("idle_we", bus.mem_we, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i[9:0]);
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_last  = 1'b1;

    // Reset held for 3 cycles with both requests high
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd1; bus.cpu_wdata = '0;
    bus.ld_req  = 1'b1; bus.ld_we  = 1'b0; bus.ld_addr  = 10'd3; bus.ld_wdata  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_acks", {bus.cpu_ack, bus.ld_ack}, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_ld_rdata", bus.ld_rdata, 0);
      chk("rst_addr", bus.mem_addr, 10'd1);
    end
    rst = 1'b1;
    serve(1'b1);   // CPU wins the first tie
    serve(1'b1);

    // Loader writes word 527, CPU reads it back
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 10'd527; bus.ld_wdata = 32'd5;
    serve(1'b1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd527;
    serve(1'b1);
    chk("fib_input", bus.cpu_rdata, 32'd5);

    // Both held for 12 cycles: cpu, ld, cpu, ld
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd3;
    bus.ld_req  = 1'b1; bus.ld_we  = 1'b0; bus.ld_addr  = 10'd4;
    for (int i = 0; i < 4; i++) serve(1'b0);
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;

    // Data isolation
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd1;
    serve(1'b1);
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 10'd0;
    serve(1'b1);
    chk("iso_cpu", bus.cpu_rdata, 32'h2019_0200);
    chk("iso_ld", bus.ld_rdata, 32'h0);

    // Reset during the ACCESS cycle of a loader read
    do_reset();
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 10'd1;
    tick();
    chk("mid_access_busy", bus.busy, 1);
    rst = 1'b0;
    tick();
    chk("mid_ld_ack", bus.ld_ack, 0);
    chk("mid_ld_rdata", bus.ld_rdata, 0);
    chk("mid_busy", bus.busy, 0);
    rst = 1'b1;
    bus.ld_req = 1'b0;
    m_last = 1'b1;
    tick();
    chk("mid_after_ack", bus.ld_ack, 0);
    chk("mid_after_busy", bus.busy, 0);
    chk("mid_after_we", bus.mem_we, 0);

    // Back-to-back CPU reads of words 3 and 4
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd3;
    serve(1'b0);
    chk("b2b_first", bus.cpu_rdata, 32'h2011_0001);
    bus.cpu_addr = 10'd4;
    serve(1'b1);
    chk("b2b_second", bus.cpu_rdata, 32'h8F37_000F);

    // Randomized transfers
    for (int r = 0; r < 40; r++) begin
      int unsigned mask;
      mask = $urandom_range(1, 3);
      bus.cpu_req   = mask[0];
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = 10'($urandom_range(0, 15));
      bus.cpu_wdata = $urandom;
      bus.ld_req    = mask[1];
      bus.ld_we     = 1'($urandom_range(0, 1));
      bus.ld_addr   = 10'($urandom_range(0, 15));
      bus.ld_wdata  = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (bus.cpu_req || bus.ld_req) serve(1'b1);
      end
      if (($urandom_range(0, 3)) == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
